// File: rtl/sobel_pixel_packer.sv
// sobel_pixel_packer: drains the Sobel pixel FIFO (first-word-fall-through),
// packs four consecutive 8-bit pixels into a 32-bit word (pixel n in [7:0])
// and writes it to the word FIFO with start-of-frame / end-of-line sideband.
// Tracks lane/column/row position and pulses frame_done after each frame.
// Optional: define PACKER_CHECKSUM_EN to add a per-frame pixel-sum output
// (frame_checksum); without it the port and logic are absent.
module sobel_pixel_packer #(
  parameter int IMG_WIDTH   = 720,
  parameter int IMG_HEIGHT  = 540,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   in_rd_en,
  input  logic                   in_empty,
  input  logic [7:0]             pixel_in,
  output logic                   out_wr_en,
  input  logic                   out_full,
  output logic [31:0]            word_out,
  output logic                   sof_out,
  output logic                   eol_out,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count
`ifdef PACKER_CHECKSUM_EN
  ,
  output logic [31:0]            frame_checksum
`endif
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_SOF  = COL_W'(3);

  typedef enum logic {
    S_RUN,
    S_FEND
  } state_t;

  state_t           state;
  logic [1:0]       lane;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       byte0;
  logic [7:0]       byte1;
  logic [7:0]       byte2;
  logic             rd;
  logic             wr;

  // Read/write strobes and the packed word are combinational so the word is
  // written in the same cycle its fourth pixel is read; rst blanks them.
  always_comb begin
    rd         = 1'b0;
    wr         = 1'b0;
    word_out   = '0;
    sof_out    = 1'b0;
    eol_out    = 1'b0;
    if (!rst && state == S_RUN && !in_empty && (lane != 2'd3 || !out_full)) begin
      rd = 1'b1;
    end
    if (rd && lane == 2'd3) begin
      wr       = 1'b1;
      word_out = {pixel_in, byte2, byte1, byte0};
      sof_out  = (row == '0) && (col == COL_SOF);
      eol_out  = (col == COL_LAST);
    end
    in_rd_en   = rd;
    out_wr_en  = wr;
    frame_done = (state == S_FEND);
  end

  // Position tracking, pixel staging and frame accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      lane        <= '0;
      col         <= '0;
      row         <= '0;
      byte0       <= '0;
      byte1       <= '0;
      byte2       <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (rd) begin
            if (lane != 2'd3) begin
              case (lane)
                2'd0:    byte0 <= pixel_in;
                2'd1:    byte1 <= pixel_in;
                default: byte2 <= pixel_in;
              endcase
              lane <= lane + 2'd1;
              col  <= col + 1'b1;
            end else begin
              lane <= '0;
              if (col == COL_LAST) begin
                col <= '0;
                if (row == ROW_LAST) begin
                  row         <= '0;
                  frame_count <= frame_count + 1'b1;
                  state       <= S_FEND;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        S_FEND:  state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef PACKER_CHECKSUM_EN
  logic [31:0] csum_acc;

  // Sum every consumed pixel; publish and clear on the frame-end cycle,
  // which never coincides with a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_acc       <= '0;
      frame_checksum <= '0;
    end else if (state == S_FEND) begin
      frame_checksum <= csum_acc;
      csum_acc       <= '0;
    end else if (rd) begin
      csum_acc <= csum_acc + {24'd0, pixel_in};
    end
  end
`endif

endmodule

// File: tb/tb_sobel_pixel_packer.sv
// Self-checking bench for sobel_pixel_packer: a FWFT pixel-FIFO model feeds
// the DUT, a reference model pushes expected words to a scoreboard queue,
// and each scenario task compares captured writes against it.
module tb_sobel_pixel_packer;

  localparam int TW  = 720;
  localparam int TH  = 6;
  localparam int FCW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_rd_en;
  logic           in_empty = 1'b1;
  logic [7:0]     pixel_in = '0;
  logic           out_wr_en;
  logic           out_full = 1'b0;
  logic [31:0]    word_out;
  logic           sof_out;
  logic           eol_out;
  logic           frame_done;
  logic [FCW-1:0] frame_count;
`ifdef PACKER_CHECKSUM_EN
  logic [31:0]    frame_checksum;
`endif

  sobel_pixel_packer #(
    .IMG_WIDTH  (TW),
    .IMG_HEIGHT (TH),
    .FRAME_CNT_W(FCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .pixel_in   (pixel_in),
    .out_wr_en  (out_wr_en),
    .out_full   (out_full),
    .word_out   (word_out),
    .sof_out    (sof_out),
    .eol_out    (eol_out),
    .frame_done (frame_done),
    .frame_count(frame_count)
`ifdef PACKER_CHECKSUM_EN
    ,
    .frame_checksum(frame_checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic        sof;
    logic        eol;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  bit         obs_ok_q[$];
  logic [7:0] src_q[$];

  int checks = 0;
  int passed = 0;

  int unsigned gap_pct   = 0;
  bit          hold_full = 1'b0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, fd_cnt = 0, fd_cyc = 0, last_wr_cyc = 0;
  int bad_rd = 0, rd_in_fd = 0, fd_nonempty = 0, idle_nz = 0;

  // reference model state
  int          m_lane = 0, m_col = 0, m_row = 0;
  logic [7:0]  m_stage[3];
  logic [31:0] m_sum = '0;
  logic [31:0] m_fsum = '0;

  // FWFT FIFO model and output monitor; inputs change on negedge, outputs
  // are sampled 1 ns later, well before the consuming rising edge.
  always @(negedge clk) begin
    in_empty = (src_q.size() == 0) || ($urandom_range(99) < gap_pct);
    pixel_in = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
    out_full = hold_full;
    #1;
    if (in_rd_en) begin
      rd_cnt++;
      if (in_empty) bad_rd++;
      else void'(src_q.pop_front());
    end
    if (out_wr_en) begin
      wr_cnt++;
      obs_q.push_back(wr_t'{word_out, sof_out, eol_out});
      obs_ok_q.push_back(in_rd_en && (pixel_in == word_out[31:24]));
      last_wr_cyc = cyc;
    end else if (word_out != '0 || sof_out || eol_out) begin
      idle_nz++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
      if (in_rd_en) rd_in_fd++;
      if (!in_empty) fd_nonempty++;
    end
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic clr_counters();
    rd_cnt = 0; wr_cnt = 0; fd_cnt = 0; fd_cyc = 0; last_wr_cyc = 0;
    bad_rd = 0; rd_in_fd = 0; fd_nonempty = 0; idle_nz = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    src_q.delete(); exp_q.delete(); obs_q.delete(); obs_ok_q.delete();
    hold_full = 1'b0; gap_pct = 0;
    m_lane = 0; m_col = 0; m_row = 0; m_sum = '0; m_fsum = '0;
    clr_counters();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Push a pixel into the FIFO and the expected result into the scoreboard.
  task automatic feed(input logic [7:0] p);
    src_q.push_back(p);
    m_sum = m_sum + 32'(p);
    if (m_lane < 3) begin
      m_stage[m_lane] = p;
      m_lane++;
      m_col++;
    end else begin
      exp_q.push_back(wr_t'{{p, m_stage[2], m_stage[1], m_stage[0]},
                            (m_row == 0 && m_col == 3), (m_col == TW - 1)});
      m_lane = 0;
      if (m_col == TW - 1) begin
        m_col = 0;
        if (m_row == TH - 1) begin
          m_row = 0; m_fsum = m_sum; m_sum = '0;
        end else m_row++;
      end else m_col++;
    end
  endtask

  task automatic wait_drain(input int budget, output int left);
    int n = 0;
    while (src_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #2 left = src_q.size();
  endtask

  task automatic test_reset();
    src_q.push_back(8'h5A);
    repeat (3) @(posedge clk);
    #2;
    checks++; if (in_rd_en !== 1'b0) $display("FAIL reset_rd: got %b want 0", in_rd_en); else passed++;
    checks++; if (out_wr_en !== 1'b0) $display("FAIL reset_wr: got %b want 0", out_wr_en); else passed++;
    checks++; if (word_out !== 32'h0) $display("FAIL reset_word: got %h want 0", word_out); else passed++;
    checks++; if ({sof_out, eol_out} !== 2'b00) $display("FAIL reset_side: got %b want 00", {sof_out, eol_out}); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", frame_done); else passed++;
    checks++; if (frame_count !== '0) $display("FAIL reset_fc: got %0d want 0", frame_count); else passed++;
`ifdef PACKER_CHECKSUM_EN
    checks++; if (frame_checksum !== 32'h0) $display("FAIL reset_csum: got %h want 0", frame_checksum); else passed++;
`endif
    src_q.delete();
    #1 rst = 1'b0;
  endtask

  task automatic test_first_word();
    int left; wr_t w; bit ok;
    do_reset();
    feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
    wait_drain(100, left);
    checks++; if (left != 0) $display("FAIL first_drain: got %0d left want 0", left); else passed++;
    checks++; if (obs_q.size() != 1) $display("FAIL first_count: got %0d writes want 1", obs_q.size()); else passed++;
    w  = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    ok = (obs_ok_q.size() != 0) ? obs_ok_q.pop_front() : 1'b0;
    checks++; if (w.word !== 32'h04030201) $display("FAIL first_word: got %h want 04030201", w.word); else passed++;
    checks++; if (w.sof !== 1'b1) $display("FAIL first_sof: got %b want 1", w.sof); else passed++;
    checks++; if (w.eol !== 1'b0) $display("FAIL first_eol: got %b want 0", w.eol); else passed++;
    checks++; if (ok !== 1'b1) $display("FAIL first_same_cycle: got %b want 1", ok); else passed++;
  endtask

  task automatic test_line();
    int left; wr_t w, e;
    do_reset();
    for (int i = 0; i < TW; i++) feed(8'hAA);
    wait_drain(2000, left);
    checks++; if (wr_cnt != TW / 4) $display("FAIL line_count: got %0d want %0d", wr_cnt, TW / 4); else passed++;
    for (int i = 0; i < TW / 4; i++) begin
      w = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      e = exp_q.pop_front();
      checks++;
      if (w !== e || w.word !== 32'hAAAAAAAA)
        $display("FAIL line_write[%0d]: got %h/%b%b want %h/%b%b", i, w.word, w.sof, w.eol, e.word, e.sof, e.eol);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int left, rd0; wr_t w, e;
    do_reset();
    feed(8'h10); feed(8'h20); feed(8'h30);
    wait_drain(100, left);
    @(posedge clk); #2 hold_full = 1'b1;
    rd0 = rd_cnt;
    feed(8'h40);
    repeat (10) @(posedge clk);
    #2;
    checks++; if (rd_cnt != rd0) $display("FAIL bp_stall_rd: got %0d reads want 0", rd_cnt - rd0); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL bp_stall_wr: got %0d writes want 0", obs_q.size()); else passed++;
    checks++; if (src_q.size() != 1) $display("FAIL bp_head: got %0d queued want 1", src_q.size()); else passed++;
    hold_full = 1'b0;
    wait_drain(100, left);
    w = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    e = exp_q.pop_front();
    checks++; if (w !== e || w.word !== 32'h40302010) $display("FAIL bp_word: got %h want 40302010", w.word); else passed++;
    // lanes 0..2 keep reading with the word FIFO full
    hold_full = 1'b1;
    feed(8'h51); feed(8'h52); feed(8'h53); feed(8'h54);
    repeat (10) @(posedge clk);
    #2;
    checks++; if (src_q.size() != 1) $display("FAIL bp_lane_nostall: got %0d queued want 1", src_q.size()); else passed++;
    hold_full = 1'b0;
    wait_drain(100, left);
    w = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    e = exp_q.pop_front();
    checks++; if (w !== e || w.word !== 32'h54535251) $display("FAIL bp_word2: got %h/%b want 54535251/0", w.word, w.sof); else passed++;
  endtask

  task automatic test_frame();
    int left, errs; wr_t w, e;
    do_reset();
    gap_pct = 40;
    for (int i = 0; i < TW * TH; i++) feed(8'($urandom));
    wait_drain(40000, left);
    gap_pct = 0;
    checks++; if (left != 0) $display("FAIL frame_drain: got %0d left want 0", left); else passed++;
    checks++; if (wr_cnt != TW * TH / 4) $display("FAIL frame_writes: got %0d want %0d", wr_cnt, TW * TH / 4); else passed++;
    errs = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      w = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      if (w !== e && errs < 5) $display("FAIL frame_write: got %h/%b%b want %h/%b%b", w.word, w.sof, w.eol, e.word, e.sof, e.eol);
      if (w !== e) errs++;
    end
    checks++; if (errs != 0) $display("FAIL frame_words: got %0d bad writes want 0", errs); else passed++;
    checks++; if (fd_cnt != 1) $display("FAIL frame_fd_count: got %0d want 1", fd_cnt); else passed++;
    checks++; if (fd_cyc != last_wr_cyc + 1) $display("FAIL frame_fd_time: got cycle %0d want %0d", fd_cyc, last_wr_cyc + 1); else passed++;
    checks++; if (rd_in_fd != 0) $display("FAIL frame_rd_in_fd: got %0d want 0", rd_in_fd); else passed++;
    checks++; if (frame_count !== FCW'(1)) $display("FAIL frame_count: got %0d want 1", frame_count); else passed++;
    checks++; if (bad_rd != 0) $display("FAIL frame_rd_empty: got %0d want 0", bad_rd); else passed++;
    checks++; if (idle_nz != 0) $display("FAIL frame_idle_zero: got %0d want 0", idle_nz); else passed++;
`ifdef PACKER_CHECKSUM_EN
    checks++; if (frame_checksum !== m_fsum) $display("FAIL frame_csum: got %h want %h", frame_checksum, m_fsum); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    int left, errs; wr_t w, e;
    clr_counters();
    for (int i = 0; i < TW * TH; i++) feed(8'hFF);
    for (int i = 1; i <= 8; i++) feed(8'(i));
    wait_drain(20000, left);
    errs = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      w = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      if (w !== e && errs < 5) $display("FAIL b2b_write: got %h/%b%b want %h/%b%b", w.word, w.sof, w.eol, e.word, e.sof, e.eol);
      if (w !== e) errs++;
    end
    checks++; if (errs != 0 || wr_cnt != TW * TH / 4 + 2) $display("FAIL b2b_words: got %0d bad, %0d writes want 0, %0d", errs, wr_cnt, TW * TH / 4 + 2); else passed++;
    checks++; if (fd_cnt != 1) $display("FAIL b2b_fd_count: got %0d want 1", fd_cnt); else passed++;
    checks++; if (fd_nonempty != 1 || rd_in_fd != 0) $display("FAIL b2b_fend_noread: got nonempty=%0d reads=%0d want 1,0", fd_nonempty, rd_in_fd); else passed++;
    checks++; if (frame_count !== FCW'(2)) $display("FAIL b2b_count: got %0d want 2", frame_count); else passed++;
`ifdef PACKER_CHECKSUM_EN
    checks++; if (frame_checksum !== 32'(TW * TH * 255)) $display("FAIL b2b_csum: got %h want %h", frame_checksum, 32'(TW * TH * 255)); else passed++;
`endif
  endtask

  task automatic test_reset_midframe();
    int left; wr_t w;
    obs_q.delete();
    feed(8'hEE); feed(8'hDD);
    wait_drain(100, left);
    checks++; if (obs_q.size() != 0) $display("FAIL mid_partial: got %0d writes want 0", obs_q.size()); else passed++;
    do_reset();
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    wait_drain(100, left);
    checks++; if (obs_q.size() != 1) $display("FAIL mid_count: got %0d writes want 1", obs_q.size()); else passed++;
    w = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
    checks++; if (w.word !== 32'h44332211) $display("FAIL mid_word: got %h want 44332211", w.word); else passed++;
    checks++; if ({w.sof, w.eol} !== 2'b10) $display("FAIL mid_side: got %b want 10", {w.sof, w.eol}); else passed++;
    checks++; if (frame_count !== '0) $display("FAIL mid_fc: got %0d want 0", frame_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_line();
    test_backpressure();
    test_frame();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
